// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// The FSM state encoding and the operation counter width are defined here.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // A single-bit counter is still needed when WIDTH is 1.
    function automatic int count_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: computes x - y - bin, producing a difference bit and a borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single full-subtractor cell.
// Results land on held output registers together with a one-cycle done pulse.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = count_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_sr_q, d_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    count_q, count_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;

    logic             fs_diff;
    logic             fs_bout;
    logic [WIDTH-1:0] d_sr_shift;
    logic             unused_d_lsb;

    full_subtractor u_fs (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts the register holds the full result.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_dshift
            if (gi == WIDTH - 1) begin : g_top
                assign d_sr_shift[gi] = fs_diff;
            end else begin : g_mid
                assign d_sr_shift[gi] = d_sr_q[gi+1];
            end
        end
    endgenerate

    // The LSB of the partial-result register is shifted out and never read.
    assign unused_d_lsb = d_sr_q[0];

    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        d_sr_d       = d_sr_q;
        diff_d       = diff_q;
        count_d      = count_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                d_sr_d   = d_sr_shift;
                borrow_d = fs_bout;
                count_d  = count_q + CW'(1);
                if (count_q == LAST) begin
                    diff_d       = d_sr_shift;
                    borrow_out_d = fs_bout;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            d_sr_q       <= '0;
            diff_q       <= '0;
            count_q      <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            d_sr_q       <= d_sr_d;
            diff_q       <= diff_d;
            count_q      <= count_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign done        = (state_q == DONE);
    assign diff        = diff_q;
    assign borrow_out  = borrow_out_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `a - b` LSB-first, one bit per clock, through a single combinational full-subtractor cell and a registered borrow. It is the inverse-direction companion to the team's ripple adder cells: same bit-level arithmetic style, but it subtracts and trades area for latency. Operands enter through a valid/ready start handshake. The result is presented on held output registers with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 8, operand and result width in bits; legal range is WIDTH ≥ 1.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start_valid`  in  1  operands on `a`/`b` are valid
- `start_ready`  out  1  block can accept operands (high only in IDLE)
- `a`  in  WIDTH  minuend, sampled on the handshake edge
- `b`  in  WIDTH  subtrahend, sampled on the handshake edge
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse: `diff`/`borrow_out` just updated
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`
- `borrow_out`  out  1  final borrow; 1 iff `a < b` (unsigned)

## Operation
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, `diff`=0, `borrow_out`=0, `done`=0, `busy`=0, all internal shift/borrow/count registers=0. `start_ready`=1 in the cycle after reset deasserts.
- **IDLE:**
  - `start_ready`=1.
  - On `start_valid & start_ready` at an edge: load `a_sr`←`a`, `b_sr`←`b`, `borrow`←0, `count`←0, and go to RUN.
- **RUN** (exactly WIDTH cycles), each edge:
  - Compute `{d, bo}` = full_subtractor(`a_sr[0]`, `b_sr[0]`, `borrow`).
  - Shift `d` into the MSB of `d_sr` (right shift).
  - Shift `a_sr` and `b_sr` right by 1.
  - Set `borrow`←`bo` and `count`←`count+1`.
- **RUN exit:** on the edge where `count==WIDTH-1`, additionally load `diff`←final `{d, d_sr[WIDTH-1:1]}` and `borrow_out`←`bo`, then go to DONE.
- **DONE:** `done`=1 for this single cycle. Next edge returns to IDLE unconditionally.
- `start_valid` while not in IDLE is ignored. Operands are not latched, and no request is queued.
- `diff`/`borrow_out` hold their value from DONE until the final RUN edge of the next operation. They never show partial results.
- Arithmetic rules:
  - `d = x ^ y ^ bin`
  - `bo = (~x & y) | (~(x ^ y) & bin)`
  - Initial borrow is 0.
- Counter width is `max(1, $clog2(WIDTH))`.
- WIDTH=1: RUN lasts one cycle.

## Timing
- Handshake edge E0. RUN edges are E1..E_WIDTH. Outputs update at E_WIDTH.
- `done` is high during the cycle between E_WIDTH and E_WIDTH+1. `start_ready` goes high after E_WIDTH+1.
- Latency from accept edge to `done` high is WIDTH cycles. Throughput is one operation per WIDTH+2 cycles.
- With `start_valid` held high continuously, a new operation is accepted on E_WIDTH+2.
- Reset mid-operation (RUN or DONE): at the reset edge, all outputs go to reset values. `done` does not pulse, and the aborted result is discarded.
- Reset has priority over a simultaneous handshake.
- All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.

## Structure
- Package `serial_sub_pkg`:
  - state enum `sub_state_t` {IDLE, RUN, DONE}, 2-bit
  - a `count_w` function returning `max(1, $clog2(WIDTH))`
- Sub-module `full_subtractor`: purely combinational, with inputs `a`, `b`, `bin` and outputs `diff`, `bout`. It is instantiated once in the datapath, mirroring the full-adder cell.
- Top-level `serial_subtractor` contains the FSM, counter, three shift registers, the borrow flop and the output registers.

## Test plan
- WIDTH=8, `a`=100, `b`=37 → `diff`=63, `borrow_out`=0; `done` high exactly 8 cycles after the accept edge, for 1 cycle.
- `a`=5, `b`=10 → `diff`=8'hFB, `borrow_out`=1. Also `a`=0, `b`=1 → 8'hFF, `borrow_out`=1 (full borrow ripple).
- `a`=8'h80, `b`=8'h80 → `diff`=0, `borrow_out`=0. Also `a`=8'hFF, `b`=0 → 8'hFF, `borrow_out`=0.
- Hold `start_valid`=1 with changing operands:
  - accepts occur only when `start_ready`=1, spaced 10 cycles apart;
  - operands presented during RUN/DONE are ignored;
  - `diff` stays stable between `done` pulses.
- Assert `rst` for 1 cycle at RUN cycle 4 of `a`=200, `b`=3 → no `done` pulse, `diff`=0, `borrow_out`=0, `start_ready`=1 next cycle. A subsequent `a`=200, `b`=3 then gives 197.
- WIDTH=1, all four `{a,b}` pairs → `diff`=`a^b`, `borrow_out`=`~a&b`; `done` 1 cycle after accept.
